// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl : HI/LO multiply/divide unit control (external multiplier, 1-bit/cycle divider)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_ctrl #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        es_valid,
   input  logic [3:0]  es_op,
   input  logic [31:0] es_src1,
   input  logic [31:0] es_src2,
   input  logic        es_cancel,
   input  logic        es_advance,
   input  logic        pipeline_flush,
   output logic        mdu_stall,
   output logic [31:0] mdu_rdata,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_signed,
   input  logic [63:0] mul_p,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_LAST = 6'd31;

   state_t      state;
   state_t      state_nxt;
   logic [5:0]  cnt;
   logic [63:0] result;

   logic [31:0] mul_a_q;
   logic [31:0] mul_b_q;
   logic        mul_signed_q;

   logic [31:0] div_rem;
   logic [31:0] div_quo;
   logic [31:0] div_dsr;
   logic [31:0] div_src1;
   logic        div_neg_q;
   logic        div_neg_r;
   logic        div_zero;

   logic        op_mul;
   logic        op_div;
   logic        start;
   logic        mt_hi;
   logic        mt_lo;
   logic        stall;
   logic        capture_mul;
   logic        finish_div;
   logic        commit;

   logic [32:0] div_shift;
   logic [31:0] div_diff;
   logic        div_ge;
   logic [31:0] rem_nxt;
   logic [31:0] quo_nxt;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [63:0] div_result;

   logic        src1_neg;
   logic        src2_neg;

   always_comb begin
      op_mul = (es_op == 4'd1) || (es_op == 4'd2);
      op_div = (es_op == 4'd3) || (es_op == 4'd4);
      start  = (state == IDLE) && es_valid && (op_mul || op_div)
               && !es_cancel && !pipeline_flush;
      mt_hi  = (state == IDLE) && es_valid && es_advance && !es_cancel
               && !pipeline_flush && (es_op == 4'd5);
      mt_lo  = (state == IDLE) && es_valid && es_advance && !es_cancel
               && !pipeline_flush && (es_op == 4'd6);
      src1_neg = (es_op == 4'd3) && es_src1[31];
      src2_neg = (es_op == 4'd3) && es_src2[31];
   end

   // Restoring step: the partial remainder stays below the divisor, so a
   // 32-bit difference is exact whenever the trial subtraction succeeds.
   always_comb begin
      div_shift  = {div_rem, div_quo[31]};
      div_diff   = div_shift[31:0] - div_dsr;
      div_ge     = div_shift >= {1'b0, div_dsr};
      rem_nxt    = div_ge ? div_diff : div_shift[31:0];
      quo_nxt    = {div_quo[30:0], div_ge};
      quo_fix    = div_neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
      rem_fix    = div_neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
      div_result = div_zero ? {div_src1, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      stall       = 1'b0;
      capture_mul = 1'b0;
      finish_div  = 1'b0;
      commit      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               stall     = 1'b1;
               state_nxt = op_mul ? MUL : DIV;
            end
         end
         MUL: begin
            stall = !es_cancel;
            if (pipeline_flush || es_cancel) begin
               state_nxt = IDLE;
            end else if (cnt == MUL_LAST) begin
               capture_mul = 1'b1;
               state_nxt   = DONE;
            end
         end
         DIV: begin
            stall = !es_cancel;
            if (pipeline_flush || es_cancel) begin
               state_nxt = IDLE;
            end else if (cnt == DIV_LAST) begin
               finish_div = 1'b1;
               state_nxt  = DONE;
            end
         end
         DONE: begin
            if (pipeline_flush) begin
               state_nxt = IDLE;
            end else if (es_advance) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= 6'd0;
         result       <= 64'd0;
         mul_a_q      <= 32'd0;
         mul_b_q      <= 32'd0;
         mul_signed_q <= 1'b0;
         div_rem      <= 32'd0;
         div_quo      <= 32'd0;
         div_dsr      <= 32'd0;
         div_src1     <= 32'd0;
         div_neg_q    <= 1'b0;
         div_neg_r    <= 1'b0;
         div_zero     <= 1'b0;
         hi           <= 32'd0;
         lo           <= 32'd0;
      end else begin
         if (start) begin
            cnt <= 6'd0;
         end else if ((state == MUL) || (state == DIV)) begin
            cnt <= cnt + 6'd1;
         end

         if (start && op_mul) begin
            mul_a_q      <= es_src1;
            mul_b_q      <= es_src2;
            mul_signed_q <= (es_op == 4'd1);
         end

         if (start && op_div) begin
            div_rem   <= 32'd0;
            div_quo   <= src1_neg ? (~es_src1 + 32'd1) : es_src1;
            div_dsr   <= src2_neg ? (~es_src2 + 32'd1) : es_src2;
            div_src1  <= es_src1;
            div_neg_q <= src1_neg ^ src2_neg;
            div_neg_r <= src1_neg;
            div_zero  <= (es_src2 == 32'd0);
         end else if (state == DIV) begin
            div_rem <= rem_nxt;
            div_quo <= quo_nxt;
         end

         if (capture_mul) begin
            result <= mul_p;
         end else if (finish_div) begin
            result <= div_result;
         end

         if (commit) begin
            hi <= result[63:32];
            lo <= result[31:0];
         end else if (mt_hi) begin
            hi <= es_src1;
         end else if (mt_lo) begin
            lo <= es_src1;
         end
      end
   end

   // Operands reach the multiplier in the start cycle itself, then from the latch.
   always_comb begin
      mdu_stall  = stall;
      mul_a      = (start && op_mul) ? es_src1 : mul_a_q;
      mul_b      = (start && op_mul) ? es_src2 : mul_b_q;
      mul_signed = (start && op_mul) ? (es_op == 4'd1) : mul_signed_q;
      mdu_rdata  = 32'd0;
      if (es_valid && (es_op == 4'd7)) begin
         mdu_rdata = hi;
      end else if (es_valid && (es_op == 4'd8)) begin
         mdu_rdata = lo;
      end
   end

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, external multiplier latency in cycles (legal 1..4).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port es_valid  in  1  valid instruction present in EXE.
REQ-005 SHALL have port es_op  in  4  HI/LO op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as none.
REQ-006 SHALL have ports es_src1, es_src2  in  32 each  rs / rt values of the EXE instruction.
REQ-007 SHALL have port es_cancel  in  1  EXE instruction carries an exception; must not commit.
REQ-008 SHALL have port es_advance  in  1  EXE instruction leaves EXE at this edge.
REQ-009 SHALL have port pipeline_flush  in  1  eret/exception flush (OR of flush sources).
REQ-010 SHALL have port mdu_stall  out  1  holds EXE (blocks es_ready_go).
REQ-011 SHALL have port mdu_rdata  out  32  HI (op 7) or LO (op 8) value, else 0.
REQ-012 SHALL have ports mul_a, mul_b  out  32 each, mul_signed  out  1  multiplier operands.
REQ-013 SHALL have port mul_p  in  64  product, valid MUL_LAT cycles after operands presented.
REQ-014 SHALL have ports hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-016 SHALL start an op in IDLE when es_valid & es_op in 1..4 & !es_cancel & !pipeline_flush (start cycle S).
REQ-017 SHALL, for MULT/MULTU, drive mul_a/mul_b from es_src1/es_src2 in cycle S and from latched copies afterwards; mul_signed=1 for MULT.
REQ-018 SHALL stay in MUL for MUL_LAT cycles, capture mul_p into a result register at the edge ending cycle S+MUL_LAT, then enter DONE.
REQ-019 SHALL, for DIV/DIVU, latch operand magnitudes (signed: absolute value) at end of S; perform one restoring quotient bit per cycle in S+1..S+32; at edge ending S+32 apply sign fix (quotient negated iff signs differ, remainder takes dividend sign) and enter DONE.
REQ-020 SHALL, for divisor 0, complete with normal latency, result HI=es_src1, LO=32'hFFFFFFFF, no exception.
REQ-021 SHALL assert mdu_stall combinationally in the start condition of REQ-016 and in MUL and DIV; deassert in IDLE otherwise and in DONE.
REQ-022 SHALL hold result in DONE until es_advance; on es_advance & !pipeline_flush write HI=result[63:32]/remainder, LO=result[31:0]/quotient, go IDLE.
REQ-023 SHALL write HI (op 5) or LO (op 6) with es_src1 in IDLE at an edge with es_valid & es_advance & !es_cancel & !pipeline_flush; no stall.
REQ-024 SHALL drive mdu_rdata combinationally from current HI/LO for ops 7/8 when es_valid, else 0; no stall.
REQ-025 SHALL, on pipeline_flush in any state, go IDLE next cycle and leave HI/LO unchanged; flush beats start, final capture and DONE commit in the same cycle.
REQ-026 SHALL, on es_cancel in MUL or DIV, abort to IDLE next cycle with mdu_stall low in that cycle and HI/LO unchanged.
REQ-027 SHALL ignore mul_p outside MUL, and accept no new start outside IDLE.

Reset
REQ-028 SHALL, on reset (any state, including mid-division), set state IDLE, HI=LO=0, result registers 0, mdu_stall=0, mul_a=mul_b=0, mul_signed=0.
REQ-029 SHALL give reset priority over flush, start and commit.

Verification
REQ-030 MULT src1=32'hFFFFFFFE, src2=3, MUL_LAT=2, es_advance high -> mdu_stall high 3 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-031 DIV src1=-7, src2=2 -> mdu_stall high 33 cycles, LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU 100/0 -> HI=100, LO=32'hFFFFFFFF.
REQ-032 DIVU in progress, pipeline_flush at iteration 10 -> IDLE next cycle, stall low, HI/LO unchanged; next MULTU 5*6 -> LO=30, HI=0.
REQ-033 DONE with es_advance low 4 cycles then high -> HI/LO written only at the advance edge; MFLO following in EXE reads new LO without stall.
REQ-034 MTHI 32'h1234 then MFHI -> mdu_rdata=32'h1234; MTLO with es_cancel=1 -> LO unchanged.
REQ-035 reset asserted in cycle 20 of a DIV -> next cycle IDLE, HI=LO=0, mdu_stall=0.
